// File: rtl/aud_slot_ctrl_pkg.sv
// Shared types and helpers for the audio slot sequencer.
//   state_t : sequencer states with fixed codes (reported on o_state)
//   slot_w  : width of the slot index for a given slot count
package aud_slot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_I2C        = 3'd1,
    ST_READY      = 3'd2,
    ST_RECD       = 3'd3,
    ST_RECD_PAUSE = 3'd4,
    ST_PLAY       = 3'd5,
    ST_PLAY_PAUSE = 3'd6
  } state_t;

  function automatic int slot_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

// File: rtl/aud_slot_ctrl_if.sv
// Control/address bus between the slot sequencer and the codec datapath
// (I2C initializer, recorder, DSP, player, SRAM mux).
//   master : the sequencer (drives starts/stops/pauses, SRAM select, address window, speed)
//   slave  : the datapath (drives init-done and the current record/play addresses)
interface aud_slot_ctrl_if #(
  parameter int ADDR_W  = 20,
  parameter int SPEED_W = 4
);
  logic               o_i2c_start;
  logic               i_i2c_finished;
  logic               o_rec_start;
  logic               o_rec_stop;
  logic               o_rec_pause;
  logic               o_dsp_start;
  logic               o_dsp_stop;
  logic               o_dsp_pause;
  logic               o_player_pause;
  logic               o_player_en;
  logic               o_sram_wr;
  logic [ADDR_W-1:0]  i_rec_addr;
  logic [ADDR_W-1:0]  i_play_addr;
  logic [ADDR_W-1:0]  o_base_addr;
  logic [ADDR_W-1:0]  o_end_addr;
  logic [SPEED_W-1:0] o_speed;
  logic               o_fast;
  logic               o_interp;

  modport master (
    output o_i2c_start, o_rec_start, o_rec_stop, o_rec_pause,
           o_dsp_start, o_dsp_stop, o_dsp_pause, o_player_pause, o_player_en,
           o_sram_wr, o_base_addr, o_end_addr, o_speed, o_fast, o_interp,
    input  i_i2c_finished, i_rec_addr, i_play_addr
  );

  modport slave (
    input  o_i2c_start, o_rec_start, o_rec_stop, o_rec_pause,
           o_dsp_start, o_dsp_stop, o_dsp_pause, o_player_pause, o_player_en,
           o_sram_wr, o_base_addr, o_end_addr, o_speed, o_fast, o_interp,
    output i_i2c_finished, i_rec_addr, i_play_addr
  );
endinterface

// File: rtl/aud_slot_table.sv
// Per-slot recorded-length table and address window for the slot sequencer.
//   i_clk, i_rst_n   : clock, async active-low reset (clears all lengths)
//   i_slot           : currently selected slot
//   i_slot_nxt       : slot selected from the next cycle on (drives registered base/end)
//   i_len_we         : store the saturated record offset as length of i_slot
//   i_rec_addr       : recorder address;  i_play_addr : DSP address
//   o_base_addr      : registered base of the selected slot
//   o_end_addr       : registered base + recorded length (play limit)
//   o_rec_full       : registered record offset reached the last word of the region
//   o_play_end       : registered play offset reached the recorded length
//   o_len_zero       : selected slot holds no recording
module aud_slot_table #(
  parameter int ADDR_W    = 20,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [SLOT_W-1:0] i_slot,
  input  logic [SLOT_W-1:0] i_slot_nxt,
  input  logic              i_len_we,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic [ADDR_W-1:0] o_base_addr,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_rec_full,
  output logic              o_play_end,
  output logic              o_len_zero
);

  localparam int SLOT_LOG2 = $clog2(NUM_SLOTS);
  // Largest offset inside one region (R-1)
  localparam logic [ADDR_W-1:0] OFF_MAX = {ADDR_W{1'b1}} >> SLOT_LOG2;

  logic [ADDR_W-1:0] r_len [NUM_SLOTS];
  logic [ADDR_W-1:0] r_rec_off;
  logic [ADDR_W-1:0] r_play_off;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_end;
  logic [ADDR_W-1:0] w_cur_base;
  logic [ADDR_W-1:0] w_nxt_base;
  logic [ADDR_W-1:0] w_len_sat;

  function automatic logic [ADDR_W-1:0] base_of(input logic [SLOT_W-1:0] slot);
    return ADDR_W'(slot) << (ADDR_W - SLOT_LOG2);
  endfunction

  assign w_cur_base = base_of(i_slot);
  assign w_nxt_base = base_of(i_slot_nxt);
  // An address below the base wraps to a huge offset; clamp it to the region
  assign w_len_sat  = (r_rec_off >= OFF_MAX) ? OFF_MAX : r_rec_off;

  assign o_rec_full  = (r_rec_off >= OFF_MAX);
  assign o_play_end  = (r_play_off >= r_len[i_slot]);
  assign o_len_zero  = (r_len[i_slot] == '0);
  assign o_base_addr = r_base;
  assign o_end_addr  = r_end;

  // Offset stage: relative address inside the selected region
  always_ff @(posedge i_clk) begin
    r_rec_off  <= i_rec_addr - w_cur_base;
    r_play_off <= i_play_addr - w_cur_base;
  end

  // Length table and address window stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_len[i] <= '0;
      r_base <= '0;
      r_end  <= '0;
    end else begin
      if (i_len_we) r_len[i_slot] <= w_len_sat;
      r_base <= w_nxt_base;
      // Slot never changes in the cycle a length is written, so the fresh
      // length can be forwarded straight into the end address.
      r_end  <= w_nxt_base + (i_len_we ? w_len_sat : r_len[i_slot_nxt]);
    end
  end

endmodule

// File: rtl/aud_slot_ctrl.sv
// Top-level sequencer for the audio record/playback datapath: codec bring-up,
// then record/playback per slot with auto-stop at slot full / recording end.
//   i_clk, i_rst_n               : clock, async active-low reset
//   i_key_rec/play/pause/slot    : single-cycle debounced key pulses
//   i_speed, i_fast, i_interp    : playback settings, latched at play start/resume
//   io_bus                       : datapath control bus (aud_slot_ctrl_if.master)
//   o_slot                       : selected slot
//   o_state                      : current state code
// Build option: AUD_SLOT_CTRL_LOOP_EN makes playback restart at the end of
// the recording instead of returning to READY.
module aud_slot_ctrl import aud_slot_ctrl_pkg::*; #(
  parameter  int ADDR_W    = 20,
  parameter  int NUM_SLOTS = 4,
  parameter  int SPEED_W   = 4,
  localparam int SLOT_W    = slot_w(NUM_SLOTS)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_key_rec,
  input  logic               i_key_play,
  input  logic               i_key_pause,
  input  logic               i_key_slot,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic               i_fast,
  input  logic               i_interp,
  aud_slot_ctrl_if.master    io_bus,
  output logic [SLOT_W-1:0]  o_slot,
  output logic [2:0]         o_state
);

  state_t              r_state, w_state_nxt;
  logic [SLOT_W-1:0]   r_slot, w_slot_nxt;
  logic                w_rec_start, w_rec_stop, w_dsp_start, w_dsp_stop;
  logic                w_len_we, w_latch_spd, w_restart;
  logic                r_rec_start, r_rec_stop, r_dsp_start, r_dsp_stop;
  logic                r_restart, r_dsp_start_d;
  logic                r_i2c_start, r_rec_pause, r_play_pause, r_player_en, r_sram_wr;
  logic [SPEED_W-1:0]  r_speed;
  logic                r_fast, r_interp;
  logic                w_rec_full, w_play_end, w_len_zero, w_end_guard;
  logic [ADDR_W-1:0]   w_base_addr, w_end_addr;

  aud_slot_table #(
    .ADDR_W    (ADDR_W),
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_table (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_slot      (r_slot),
    .i_slot_nxt  (w_slot_nxt),
    .i_len_we    (w_len_we),
    .i_rec_addr  (io_bus.i_rec_addr),
    .i_play_addr (io_bus.i_play_addr),
    .o_base_addr (w_base_addr),
    .o_end_addr  (w_end_addr),
    .o_rec_full  (w_rec_full),
    .o_play_end  (w_play_end),
    .o_len_zero  (w_len_zero)
  );

  // The play offset is stale for two cycles after a start pulse (the DSP has
  // not yet rewound), so the end compare is ignored in that window.
  assign w_end_guard = r_dsp_start | r_dsp_start_d;

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_rec_start = 1'b0;
    w_rec_stop  = 1'b0;
    w_dsp_start = 1'b0;
    w_dsp_stop  = 1'b0;
    w_len_we    = 1'b0;
    w_latch_spd = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_key_rec | i_key_play | i_key_pause | i_key_slot) w_state_nxt = ST_I2C;
      end
      ST_I2C: begin
        if (io_bus.i_i2c_finished) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        if (i_key_rec) begin
          w_state_nxt = ST_RECD;
          w_rec_start = 1'b1;
        end else if (i_key_play) begin
          if (!w_len_zero) begin
            w_state_nxt = ST_PLAY;
            w_dsp_start = 1'b1;
            w_latch_spd = 1'b1;
          end
        end else if (i_key_slot) begin
          w_slot_nxt = (r_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : r_slot + 1'b1;
        end
      end
      ST_RECD: begin
        if (i_key_rec | w_rec_full) begin
          w_state_nxt = ST_READY;
          w_rec_stop  = 1'b1;
          w_len_we    = 1'b1;
        end else if (i_key_pause) begin
          w_state_nxt = ST_RECD_PAUSE;
        end
      end
      ST_RECD_PAUSE: begin
        if (i_key_rec) begin
          w_state_nxt = ST_READY;
          w_rec_stop  = 1'b1;
          w_len_we    = 1'b1;
        end else if (i_key_pause) begin
          w_state_nxt = ST_RECD;
        end
      end
      ST_PLAY: begin
        if (i_key_play) begin
          w_state_nxt = ST_READY;
          w_dsp_stop  = 1'b1;
        end else if (r_restart) begin
          w_dsp_start = 1'b1;
          if (i_key_pause) w_state_nxt = ST_PLAY_PAUSE;
        end else if (w_play_end && !w_end_guard) begin
          w_dsp_stop = 1'b1;
`ifdef AUD_SLOT_CTRL_LOOP_EN
          w_restart  = 1'b1;
`else
          w_state_nxt = ST_READY;
`endif
        end else if (i_key_pause) begin
          w_state_nxt = ST_PLAY_PAUSE;
        end
      end
      ST_PLAY_PAUSE: begin
        if (i_key_play) begin
          w_state_nxt = ST_READY;
          w_dsp_stop  = 1'b1;
        end else if (i_key_pause) begin
          w_state_nxt = ST_PLAY;
          w_latch_spd = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output register stage: every level is derived from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_slot        <= '0;
      r_rec_start   <= 1'b0;
      r_rec_stop    <= 1'b0;
      r_dsp_start   <= 1'b0;
      r_dsp_stop    <= 1'b0;
      r_restart     <= 1'b0;
      r_dsp_start_d <= 1'b0;
      r_i2c_start   <= 1'b0;
      r_rec_pause   <= 1'b0;
      r_play_pause  <= 1'b0;
      r_player_en   <= 1'b0;
      r_sram_wr     <= 1'b0;
      r_speed       <= '0;
      r_fast        <= 1'b0;
      r_interp      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_slot        <= w_slot_nxt;
      r_rec_start   <= w_rec_start;
      r_rec_stop    <= w_rec_stop;
      r_dsp_start   <= w_dsp_start;
      r_dsp_stop    <= w_dsp_stop;
      r_restart     <= w_restart;
      r_dsp_start_d <= r_dsp_start;
      r_i2c_start   <= (w_state_nxt != ST_IDLE);
      r_rec_pause   <= (w_state_nxt == ST_RECD_PAUSE);
      r_play_pause  <= (w_state_nxt == ST_PLAY_PAUSE);
      r_player_en   <= (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_PLAY_PAUSE);
      r_sram_wr     <= (w_state_nxt == ST_RECD);
      if (w_latch_spd) begin
        r_speed  <= i_speed;
        r_fast   <= i_fast;
        r_interp <= i_interp;
      end
    end
  end

  assign io_bus.o_i2c_start    = r_i2c_start;
  assign io_bus.o_rec_start    = r_rec_start;
  assign io_bus.o_rec_stop     = r_rec_stop;
  assign io_bus.o_rec_pause    = r_rec_pause;
  assign io_bus.o_dsp_start    = r_dsp_start;
  assign io_bus.o_dsp_stop     = r_dsp_stop;
  assign io_bus.o_dsp_pause    = r_play_pause;
  assign io_bus.o_player_pause = r_play_pause;
  assign io_bus.o_player_en    = r_player_en;
  assign io_bus.o_sram_wr      = r_sram_wr;
  assign io_bus.o_base_addr    = w_base_addr;
  assign io_bus.o_end_addr     = w_end_addr;
  assign io_bus.o_speed        = r_speed;
  assign io_bus.o_fast         = r_fast;
  assign io_bus.o_interp       = r_interp;
  assign o_slot                = r_slot;
  assign o_state               = r_state;

endmodule

// File: tb/tb_aud_slot_ctrl.sv
// Directed bench for aud_slot_ctrl: pulses are matched against a queue of
// expected events, levels/addresses are checked at each step.
module tb_aud_slot_ctrl;
  import aud_slot_ctrl_pkg::*;

  localparam int ADDR_W    = 20;
  localparam int NUM_SLOTS = 4;
  localparam int SPEED_W   = 4;

  localparam int K_REC_START = 0;
  localparam int K_REC_STOP  = 1;
  localparam int K_DSP_START = 2;
  localparam int K_DSP_STOP  = 3;

  localparam int KEY_REC   = 0;
  localparam int KEY_PLAY  = 1;
  localparam int KEY_PAUSE = 2;
  localparam int KEY_SLOT  = 3;

  typedef struct {
    int                kind;
    logic [2:0]        st;
    logic [ADDR_W-1:0] end_addr;
  } ev_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               key_rec, key_play, key_pause, key_slot;
  logic [SPEED_W-1:0] speed;
  logic               fast, interp;
  logic [1:0]         slot;
  logic [2:0]         state;

  int  vectors     = 0;
  int  miscompares = 0;
  ev_t sb[$];

  aud_slot_ctrl_if #(.ADDR_W(ADDR_W), .SPEED_W(SPEED_W)) bus ();

  aud_slot_ctrl #(.ADDR_W(ADDR_W), .NUM_SLOTS(NUM_SLOTS), .SPEED_W(SPEED_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_key_rec   (key_rec),
    .i_key_play  (key_play),
    .i_key_pause (key_pause),
    .i_key_slot  (key_slot),
    .i_speed     (speed),
    .i_fast      (fast),
    .i_interp    (interp),
    .io_bus      (bus),
    .o_slot      (slot),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input int st, input int e);
    ev_t ev;
    ev.kind     = k;
    ev.st       = 3'(st);
    ev.end_addr = ADDR_W'(e);
    sb.push_back(ev);
  endtask

  task automatic pulse_seen(input int k);
    ev_t ev;
    vectors++;
    assert (sb.size() > 0) else begin
      miscompares++;
      $error("FAIL pulse_unexpected: observed kind %0d expected none", k);
    end
    if (sb.size() > 0) begin
      ev = sb.pop_front();
      check("pulse_kind", 32'(k), 32'(ev.kind));
      check("pulse_state", 32'(state), 32'(ev.st));
      check("pulse_end_addr", 32'(bus.o_end_addr), 32'(ev.end_addr));
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_rec_start) pulse_seen(K_REC_START);
    if (bus.o_rec_stop)  pulse_seen(K_REC_STOP);
    if (bus.o_dsp_start) pulse_seen(K_DSP_START);
    if (bus.o_dsp_stop)  pulse_seen(K_DSP_STOP);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic press(input int k);
    key_rec   = (k == KEY_REC);
    key_play  = (k == KEY_PLAY);
    key_pause = (k == KEY_PAUSE);
    key_slot  = (k == KEY_SLOT);
    @(posedge clk); #1;
    key_rec = 0; key_play = 0; key_pause = 0; key_slot = 0;
  endtask

  task automatic wait_state(input int exp, input string tag);
    for (int i = 0; i < 20 && state != 3'(exp); i++) @(negedge clk);
    check(tag, 32'(state), 32'(exp));
  endtask

  initial begin
    rst_n = 0; key_rec = 0; key_play = 0; key_pause = 0; key_slot = 0;
    speed = 0; fast = 0; interp = 0;
    bus.i_i2c_finished = 0; bus.i_rec_addr = '0; bus.i_play_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_i2c_start", 32'(bus.o_i2c_start), 0);
    check("rst_base", 32'(bus.o_base_addr), 0);
    check("rst_end", 32'(bus.o_end_addr), 0);
    check("rst_slot", 32'(slot), 0);
    check("rst_player_en", 32'(bus.o_player_en), 0);
    check("rst_sram_wr", 32'(bus.o_sram_wr), 0);
    @(posedge clk); #1; rst_n = 1;

    // codec bring-up
    press(KEY_SLOT); @(negedge clk);
    check("i2c_state", 32'(state), 1);
    check("i2c_start", 32'(bus.o_i2c_start), 1);
    repeat (10) @(negedge clk);
    check("i2c_wait_state", 32'(state), 1);
    bus.i_i2c_finished = 1;
    step(); @(negedge clk);
    check("ready_state", 32'(state), 2);
    check("ready_i2c_start", 32'(bus.o_i2c_start), 1);

    // slot 0 record to 0x1234, key stop
    push(K_REC_START, 3, 0);
    press(KEY_REC); @(negedge clk);
    check("rec0_state", 32'(state), 3);
    check("rec0_sram_wr", 32'(bus.o_sram_wr), 1);
    for (int a = 'h400; a < 'h1234; a += 'h400) begin
      bus.i_rec_addr = ADDR_W'(a); step();
    end
    bus.i_rec_addr = 20'h01234; step(); step();
    check("rec0_sram_wr_mid", 32'(bus.o_sram_wr), 1);
    push(K_REC_STOP, 2, 'h01234);
    press(KEY_REC); @(negedge clk);
    check("rec0_stop_state", 32'(state), 2);
    check("rec0_stop_sram_wr", 32'(bus.o_sram_wr), 0);
    check("rec0_end", 32'(bus.o_end_addr), 'h01234);

    // slot 1 record with pause, auto-stop when full
    press(KEY_SLOT); @(negedge clk);
    check("slot1_slot", 32'(slot), 1);
    check("slot1_base", 32'(bus.o_base_addr), 'h40000);
    check("slot1_end_empty", 32'(bus.o_end_addr), 'h40000);
    bus.i_rec_addr = 20'h40000; step();
    push(K_REC_START, 3, 'h40000);
    press(KEY_REC); @(negedge clk);
    check("rec1_state", 32'(state), 3);
    bus.i_rec_addr = 20'h50000; step();
    press(KEY_PAUSE); @(negedge clk);
    check("rec1_pause_state", 32'(state), 4);
    check("rec1_pause_lvl", 32'(bus.o_rec_pause), 1);
    check("rec1_pause_sram_wr", 32'(bus.o_sram_wr), 0);
    press(KEY_PAUSE); @(negedge clk);
    check("rec1_resume_state", 32'(state), 3);
    check("rec1_resume_lvl", 32'(bus.o_rec_pause), 0);
    bus.i_rec_addr = 20'h60000; step();
    bus.i_rec_addr = 20'h7FFFE; step();
    check("rec1_not_full_yet", 32'(state), 3);
    push(K_REC_STOP, 2, 'h7FFFF);
    bus.i_rec_addr = 20'h7FFFF;
    wait_state(2, "rec1_autostop_state");
    check("rec1_end", 32'(bus.o_end_addr), 'h7FFFF);
    check("rec1_base", 32'(bus.o_base_addr), 'h40000);

    // slot 2 is empty: play ignored
    press(KEY_SLOT); @(negedge clk);
    check("slot2_slot", 32'(slot), 2);
    check("slot2_base", 32'(bus.o_base_addr), 'h80000);
    check("slot2_end", 32'(bus.o_end_addr), 'h80000);
    press(KEY_PLAY); @(negedge clk);
    check("slot2_play_ignored", 32'(state), 2);
    check("slot2_player_en", 32'(bus.o_player_en), 0);

    // wrap to slot 0 and play with pause/resume
    press(KEY_SLOT); press(KEY_SLOT); @(negedge clk);
    check("slot0_wrap", 32'(slot), 0);
    check("slot0_end", 32'(bus.o_end_addr), 'h01234);
    speed = 4'd1; fast = 1; interp = 0;
    push(K_DSP_START, 5, 'h01234);
    press(KEY_PLAY); @(negedge clk);
    check("play_state", 32'(state), 5);
    check("play_player_en", 32'(bus.o_player_en), 1);
    check("play_speed", 32'(bus.o_speed), 1);
    check("play_fast", 32'(bus.o_fast), 1);
    check("play_interp", 32'(bus.o_interp), 0);
    bus.i_play_addr = 20'h00100; step();
    speed = 4'd3;
    press(KEY_PAUSE); @(negedge clk);
    check("ppause_state", 32'(state), 6);
    check("ppause_dsp", 32'(bus.o_dsp_pause), 1);
    check("ppause_player", 32'(bus.o_player_pause), 1);
    check("ppause_speed_held", 32'(bus.o_speed), 1);
    check("ppause_player_en", 32'(bus.o_player_en), 1);
    speed = 4'd5; interp = 1;
    press(KEY_PAUSE); @(negedge clk);
    check("presume_state", 32'(state), 5);
    check("presume_dsp", 32'(bus.o_dsp_pause), 0);
    check("presume_player", 32'(bus.o_player_pause), 0);
    check("presume_speed", 32'(bus.o_speed), 5);
    check("presume_interp", 32'(bus.o_interp), 1);
    bus.i_play_addr = 20'h01000; step();

    // end of recording
`ifdef AUD_SLOT_CTRL_LOOP_EN
    push(K_DSP_STOP, 5, 'h01234);
    push(K_DSP_START, 5, 'h01234);
    bus.i_play_addr = 20'h01234;
    for (int i = 0; i < 20 && !bus.o_dsp_start; i++) @(negedge clk);
    check("loop_restart_pulse", 32'(bus.o_dsp_start), 1);
    bus.i_play_addr = '0;
    repeat (4) @(negedge clk);
    check("loop_state", 32'(state), 5);
    check("loop_player_en", 32'(bus.o_player_en), 1);
    push(K_DSP_STOP, 2, 'h01234);
    press(KEY_PLAY); @(negedge clk);
    check("loop_keystop_state", 32'(state), 2);
    check("loop_keystop_player_en", 32'(bus.o_player_en), 0);
`else
    push(K_DSP_STOP, 2, 'h01234);
    bus.i_play_addr = 20'h01234;
    wait_state(2, "playend_state");
    check("playend_player_en", 32'(bus.o_player_en), 0);
`endif

    // key stop during playback, back-to-back with start
    bus.i_play_addr = '0; step();
    push(K_DSP_START, 5, 'h01234);
    press(KEY_PLAY); @(negedge clk);
    check("replay_state", 32'(state), 5);
    push(K_DSP_STOP, 2, 'h01234);
    press(KEY_PLAY); @(negedge clk);
    check("keystop_state", 32'(state), 2);
    check("keystop_player_en", 32'(bus.o_player_en), 0);

    // asynchronous reset in the middle of a recording
    bus.i_rec_addr = '0; step();
    push(K_REC_START, 3, 'h01234);
    press(KEY_REC); @(negedge clk);
    check("rec_again_state", 32'(state), 3);
    rst_n = 0; #1;
    check("midrst_state", 32'(state), 0);
    check("midrst_sram_wr", 32'(bus.o_sram_wr), 0);
    check("midrst_end", 32'(bus.o_end_addr), 0);
    check("midrst_i2c_start", 32'(bus.o_i2c_start), 0);
    @(posedge clk); #1; rst_n = 1;
    press(KEY_PAUSE);
    wait_state(2, "rerun_ready_state");
    check("rerun_slot", 32'(slot), 0);
    check("rerun_end_lost", 32'(bus.o_end_addr), 0);
    press(KEY_PLAY); @(negedge clk);
    check("rerun_play_ignored", 32'(state), 2);

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
